// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed seven-segment driver with per-frame snapshot
// Scans one digit per slot, blanks guard/disabled/leading-zero digits, registers all pins.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap_val;
  logic [3:0]    snap_en;
  logic          snap_lz;
  logic [3:0]    snap_dp;

  logic          tc;
  logic [3:0]    nib;
  logic          lz_hit;
  logic          guard_on;
  logic          blank;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tc = (cnt == CW'(REFRESH_DIV - 1));

  // A digit is a leading zero only if it and every more-significant nibble are zero.
  always_comb begin
    lz_hit = 1'b0;
    case (idx)
      2'd1:    lz_hit = (snap_val[15:4]  == 12'h000);
      2'd2:    lz_hit = (snap_val[15:8]  == 8'h00);
      2'd3:    lz_hit = (snap_val[15:12] == 4'h0);
      default: lz_hit = 1'b0;
    endcase
  end

  always_comb begin
    nib      = snap_val[{idx, 2'b00} +: 4];
    guard_on = (cnt < CW'(GUARD));
    blank    = !snap_en[idx] || (snap_lz && lz_hit) || guard_on;
    an_next  = 4'b1111;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (!blank) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = hex7(nib);
      dp_next  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= 2'd0;
      snap_val <= 16'h0000;
      snap_en  <= 4'b0000;
      snap_lz  <= 1'b0;
      snap_dp  <= 4'b0000;
      an       <= 4'b1111;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc) begin
        idx <= idx + 2'd1;
        // Frame boundary: inputs are only ever sampled here, so a digit never tears.
        if (idx == 2'd3) begin
          snap_val <= value;
          snap_en  <= digit_en;
          snap_lz  <= blank_lz;
          snap_dp  <= dp_in;
        end
      end
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int GD = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk(clk), .reset(reset), .value(value), .digit_en(digit_en),
    .blank_lz(blank_lz), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] pat [16];
  int         k;
  logic [15:0] m_val;
  logic [3:0]  m_en;
  logic        m_lz;
  logic [3:0]  m_dp;
  int          sh_idx;
  int          sh_c;
  int          sh_k;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  en;
    logic        lz;
    logic [3:0]  dpi;
    int          d;
    int          c;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got an/seg/dp=%h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model works in absolute cycles since reset: slot = k/RD, digit = slot mod 4.
  task automatic step();
    logic [11:0] e;
    int id, c, n;
    bit bl;
    if (reset) begin
      e = {4'hF, 7'h7F, 1'b1};
      k = 0; m_val = '0; m_en = '0; m_lz = 0; m_dp = '0;
      sh_idx = -1; sh_c = -1; sh_k = -1;
    end else begin
      id = (k / RD) % 4;
      c  = k % RD;
      n  = int'((m_val >> (4 * id)) & 16'hF);
      bl = !m_en[id] || (c < GD) || (m_lz && id >= 1 && (m_val >> (4 * id)) == 0);
      if (bl) e = {4'hF, 7'h7F, 1'b1};
      else    e = {4'hF & ~(4'h1 << id), pat[n], ~m_dp[id]};
      sh_idx = id; sh_c = c; sh_k = k % (4 * RD);
      if (k % (4 * RD) == 4 * RD - 1) begin
        m_val = value; m_en = digit_en; m_lz = blank_lz; m_dp = dp_in;
      end
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("model", {an, seg, dp}, e);
    checks++;
    if (!$onehot0(~an)) begin
      errors++;
      $display("FAIL onehot_an: got an=%b required at most one low", an);
    end
  endtask

  task automatic align(input int d, input int c);
    bit found = 0;
    for (int i = 0; i < 4 * RD + 2 && !found; i++) begin
      step();
      if (sh_idx == d && sh_c == c) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL align: got no slot d=%0d c=%0d required one", d, c);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30;
    pat[4] = 7'h19; pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78;
    pat[8] = 7'h00; pat[9] = 7'h10; pat[10] = 7'h08; pat[11] = 7'h03;
    pat[12] = 7'h46; pat[13] = 7'h21; pat[14] = 7'h06; pat[15] = 7'h0E;

    vt[0]  = '{16'h12AF, 4'hF, 1'b0, 4'h0, 0, 2, 4'b1110, 7'h0E, 1'b1};
    vt[1]  = '{16'h12AF, 4'hF, 1'b0, 4'h0, 1, 2, 4'b1101, 7'h08, 1'b1};
    vt[2]  = '{16'h12AF, 4'hF, 1'b0, 4'h0, 2, 2, 4'b1011, 7'h24, 1'b1};
    vt[3]  = '{16'h12AF, 4'hF, 1'b0, 4'h0, 3, 3, 4'b0111, 7'h79, 1'b1};
    vt[4]  = '{16'h12AF, 4'hF, 1'b0, 4'h0, 1, 0, 4'b1111, 7'h7F, 1'b1};
    vt[5]  = '{16'h0005, 4'hF, 1'b1, 4'h0, 3, 2, 4'b1111, 7'h7F, 1'b1};
    vt[6]  = '{16'h0005, 4'hF, 1'b1, 4'h0, 1, 2, 4'b1111, 7'h7F, 1'b1};
    vt[7]  = '{16'h0005, 4'hF, 1'b1, 4'h0, 0, 2, 4'b1110, 7'h12, 1'b1};
    vt[8]  = '{16'h0000, 4'hF, 1'b1, 4'h0, 0, 2, 4'b1110, 7'h40, 1'b1};
    vt[9]  = '{16'h0000, 4'hF, 1'b1, 4'h0, 2, 2, 4'b1111, 7'h7F, 1'b1};
    vt[10] = '{16'h8888, 4'hA, 1'b0, 4'h2, 1, 2, 4'b1101, 7'h00, 1'b0};
    vt[11] = '{16'h8888, 4'hA, 1'b0, 4'h2, 3, 2, 4'b0111, 7'h00, 1'b1};
    vt[12] = '{16'h8888, 4'hA, 1'b0, 4'h2, 0, 2, 4'b1111, 7'h7F, 1'b1};
    vt[13] = '{16'h8888, 4'hA, 1'b0, 4'h2, 2, 3, 4'b1111, 7'h7F, 1'b1};
    vt[14] = '{16'h0500, 4'hF, 1'b1, 4'h0, 1, 2, 4'b1101, 7'h40, 1'b1};
    vt[15] = '{16'h3C00, 4'h7, 1'b1, 4'h0, 3, 2, 4'b1111, 7'h7F, 1'b1};

    // Reset and first frame
    reset = 1; value = 16'h12AF; digit_en = 4'hF; blank_lz = 0; dp_in = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    end
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("first_frame_blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    end
    step();
    chk("first_slot_guard", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    step();
    chk("first_digit0", {an, seg, dp}, {4'b1110, 7'h0E, 1'b1});

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      value = vt[i].v; digit_en = vt[i].en; blank_lz = vt[i].lz; dp_in = vt[i].dpi;
      steps(2 * 4 * RD);
      align(vt[i].d, vt[i].c);
      chk($sformatf("vec%0d", i), {an, seg, dp}, {vt[i].e_an, vt[i].e_seg, vt[i].e_dp});
    end

    // Tear-free update mid-frame
    value = 16'h1111; digit_en = 4'hF; blank_lz = 0; dp_in = 4'h0;
    steps(2 * 4 * RD);
    align(1, 1);
    value = 16'h2222;
    for (int i = 0; i < 4 * RD && sh_k != 4 * RD - 1; i++) begin
      step();
      if (an != 4'hF) chk("tear_old", {5'b0, seg}, {5'b0, 7'h79});
    end
    for (int i = 0; i < 4 * RD; i++) begin
      step();
      if (an != 4'hF) chk("tear_new", {5'b0, seg}, {5'b0, 7'h24});
    end

    // Reset mid-frame during slot 2
    align(2, 1);
    reset = 1;
    step();
    chk("midreset_blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("midreset_frame_blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    end
    step();
    step();
    chk("midreset_digit0", {an, seg, dp}, {4'b1110, 7'h24, 1'b1});

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        digit_en = 4'($urandom);
        blank_lz = 1'($urandom);
        dp_in    = 4'($urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the control FSM: it takes that FSM's 16-bit display value, blanking controls and decimal points, and produces the `an`/`seg`/`dp` pins. It scans one digit per refresh slot and decodes hex. It latches the value once per frame so a digit never tears mid-scan, and it inserts a guard interval between digits to suppress ghosting.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Must be ≥ 2.
- `GUARD`, default 8: cycles at the start of each slot during which all anodes are off. Must satisfy 0 ≤ GUARD < REFRESH_DIV.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  16  four hex nibbles; digit i is `value[4i+3:4i]`, and digit 0 is the rightmost.
- `digit_en`  in  4  per-digit enable; 0 forces that digit blank.
- `blank_lz`  in  1  1 blanks leading zeros on digits 3..1.
- `dp_in`  in  4  per-digit decimal point, active-high request.
- `an`  out  4  anodes, active-low; `an[i]` drives digit i.
- `seg`  out  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal-point cathode, active-low.

## Operation
**Prescaler and digit index**
- `cnt` counts 0 to REFRESH_DIV-1, then wraps to 0.
- The cycle with `cnt == REFRESH_DIV-1` is the terminal count. At terminal count, the 2-bit digit index `idx` advances 0→1→2→3→0.

**Frame snapshot**
- A frame is 4·REFRESH_DIV cycles.
- At terminal count with `idx == 3` (the frame boundary), `snap_val <= value`, `snap_en <= digit_en`, `snap_lz <= blank_lz` and `snap_dp <= dp_in`.
- Inputs are sampled only at the frame boundary. Changes at any other time have no effect until the next frame.

**Digit decode, nibble n = `snap_val[4·idx+3 : 4·idx]`**
- The hex patterns are, in hex of {g..a}:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E

**Blank conditions for the current digit; any one blanks it**
- `snap_en[idx] == 0`.
- Leading zero: `snap_lz == 1` and `idx ≥ 1` and every nibble from `idx` up to 3 is zero. Digit 0 is never blanked by this rule.
- Guard: `cnt < GUARD`.

**Outputs**
- Blanked digit: `an = 4'b1111`, `seg = 7'h7F`, `dp = 1`.
- Lit digit: `an` has only bit `idx` low, `seg` is the pattern for n, and `dp = ~snap_dp[idx]`.

## Timing
- `an`, `seg` and `dp` are registered. They reflect `cnt`, `idx` and the snapshot of cycle N at cycle N+1, a fixed 1-cycle latency.
- Reset, applied in any cycle including mid-slot or mid-frame:
  - `cnt = 0`, `idx = 0`.
  - `snap_val = 0`, `snap_en = 4'b0000`, `snap_lz = 0`, `snap_dp = 0`.
  - `an = 4'b1111`, `seg = 7'h7F`, `dp = 1`.
- The first frame after reset is therefore entirely blank. The first real value is captured at the end of that first frame, 4·REFRESH_DIV cycles after reset deasserts.
- At most one anode is ever low. `an` is never low during cycles where the registered guard condition holds.
- Slot i lit window: cycles GUARD .. REFRESH_DIV-1 of the slot, delayed by the 1-cycle output register.
- `value` changing in the same cycle as the frame boundary: the new value is captured, because sampling is at that edge.
- `reset` asserted in the same cycle as a frame boundary: reset wins and nothing is captured.
- Arithmetic: `cnt` is clog2(REFRESH_DIV) bits wide. `idx` wraps modulo 4 naturally.

## Test plan
Benches use REFRESH_DIV=4 and GUARD=1.

1. **Reset and first frame.** Hold `reset` for 3 cycles with `value=16'h12AF` and `digit_en=4'hF`.
   - Required: `an=1111`, `seg=7F`, `dp=1` during reset and for the next 16 cycles.
   - Required: after that, the slot for digit 0 shows `an=1110`, `seg=0E` (F), starting at slot cycle 1 plus 1 cycle of latency.
2. **Full scan of 16'h12AF.**
   - Required, per slot: digit0 `an=1110`/`seg=0E`, digit1 `an=1101`/`08`, digit2 `an=1011`/`24`, digit3 `an=0111`/`79`.
   - Required: `an=1111` in the first output cycle of every slot.
   - Required: the pattern repeats every 16 cycles.
3. **Leading-zero blanking.** `value=16'h0005`, `blank_lz=1`.
   - Required: digits 3, 2 and 1 show `an=1111`; digit 0 shows `an=1110`, `seg=12`.
   - Then set `value=16'h0000`. Required: digit 0 shows `seg=40` and the other digits stay blank.
4. **Enable and decimal point.** `digit_en=4'b1010`, `dp_in=4'b0010`, `value=16'h8888`.
   - Required: only `an=1101` (with `dp=0`) and `an=0111` (with `dp=1`) are ever lit, both with `seg=00`.
   - Required: `dp=1` in every other cycle.
5. **Tear-free update.** Change `value` from 16'h1111 to 16'h2222 midway through slot 1.
   - Required: the remainder of that frame still shows `seg=79` on every lit digit.
   - Required: the next frame shows `seg=24` on every lit digit.
6. **Reset mid-frame.** Assert `reset` for 1 cycle during slot 2.
   - Required: the next output is blank, and `idx` restarts at 0.
   - Required: 16 blank cycles follow, and then the latest `value` appears on digit 0.
